// File: rtl/led_band_pkg.sv
// Shared types and width helpers for the LED band grayscale frame sequencer.
package led_band_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SHIFT,
      ST_LATCH,
      ST_DONE
   } state_t;

   // GS word = color bits followed by zero-padded LSBs
   function automatic int gs_w(input int color_w, input int added);
      return color_w + added;
   endfunction

   function automatic int bsel_w(input int color_w, input int added);
      return (gs_w(color_w, added) > 1) ? $clog2(gs_w(color_w, added)) : 1;
   endfunction

endpackage

// File: rtl/led_band_gs_sequencer_if.sv
// Control, frame-buffer read and LED driver signals of the grayscale sequencer.
interface led_band_gs_sequencer_if #(
   parameter int COLOR_DATA_WIDTH = 8,
   parameter int NB_CHANNELS      = 96
);
   localparam int AW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;

   logic                        start;
   logic                        abort;
   logic                        busy;
   logic                        done;
   logic                        rd_en;
   logic [AW-1:0]               rd_addr;
   logic [COLOR_DATA_WIDTH-1:0] rd_data;
   logic                        SCLK;
   logic                        SOUT;
   logic                        LAT;

   modport master (
      input  start, abort, rd_data,
      output busy, done, rd_en, rd_addr, SCLK, SOUT, LAT
   );

   modport slave (
      output start, abort, rd_data,
      input  busy, done, rd_en, rd_addr, SCLK, SOUT, LAT
   );

endinterface

// File: rtl/led_band_GS_controller.sv
// Selects the serial bit of the current grayscale word (color bits + zero LSBs).
module led_band_GS_controller
   import led_band_pkg::*;
#(
   parameter int COLOR_DATA_WIDTH  = 8,
   parameter int NB_ADDED_LSB_BITS = 1
) (
   input  logic [bsel_w(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS)-1:0] bit_sel,
   input  logic [COLOR_DATA_WIDTH-1:0]                             r_data,
   output logic                                                    sout
);
   localparam int GS_W = gs_w(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS);

   logic [GS_W-1:0] gs_word;

   generate
      if (NB_ADDED_LSB_BITS > 0) begin : g_pad
         assign gs_word = {r_data, {NB_ADDED_LSB_BITS{1'b0}}};
      end else begin : g_nopad
         assign gs_word = r_data;
      end
   endgenerate

   // bit_sel can encode values above GS_W-1 when GS_W is not a power of two
   assign sout = (int'(bit_sel) < GS_W) ? gs_word[bit_sel] : 1'b0;

endmodule

// File: rtl/led_band_gs_sequencer.sv
// Shifts one grayscale frame (channel NB_CHANNELS-1 first) into an LED driver chain, then latches.
module led_band_gs_sequencer
   import led_band_pkg::*;
#(
   parameter int COLOR_DATA_WIDTH  = 8,
   parameter int NB_ADDED_LSB_BITS = 1,
   parameter int NB_CHANNELS       = 96,
   parameter int SCLK_DIV          = 2,
   parameter int LAT_WIDTH         = 2
) (
   input  logic                    clk,
   input  logic                    nrst,
   led_band_gs_sequencer_if.master bus
);
   localparam int GS_W   = gs_w(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS);
   localparam int BSEL_W = bsel_w(COLOR_DATA_WIDTH, NB_ADDED_LSB_BITS);
   localparam int AW     = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
   localparam int PH_W   = $clog2(2 * SCLK_DIV);
   localparam int LC_W   = $clog2(SCLK_DIV + LAT_WIDTH);

   localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
   localparam logic [PH_W-1:0]   PH_HI    = PH_W'(SCLK_DIV);
   localparam logic [LC_W-1:0]   LC_LAST  = LC_W'(SCLK_DIV + LAT_WIDTH - 1);
   localparam logic [LC_W-1:0]   LC_LAT   = LC_W'(SCLK_DIV);
   localparam logic [AW-1:0]     CHAN_TOP = AW'(NB_CHANNELS - 1);
   localparam logic [BSEL_W-1:0] BSEL_TOP = BSEL_W'(GS_W - 1);

   state_t                      state, state_nx;
   logic [AW-1:0]               chan;
   logic [BSEL_W-1:0]           bit_sel;
   logic [PH_W-1:0]             phase;
   logic [LC_W-1:0]             lat_cnt;
   logic [COLOR_DATA_WIDTH-1:0] r_data;

   logic ph_wrap, bit_last, chan_last;

   assign ph_wrap   = (phase == PH_LAST);
   assign bit_last  = (bit_sel == '0);
   assign chan_last = (chan == '0);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (bus.start) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_SHIFT;
            ST_SHIFT: if (ph_wrap && bit_last) state_nx = chan_last ? ST_LATCH : ST_FETCH;
            ST_LATCH: if (lat_cnt == LC_LAST) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      bus.rd_en = 1'b0;
      bus.SCLK  = 1'b0;
      bus.LAT   = 1'b0;
      case (state)
         ST_FETCH: begin
            bus.busy  = 1'b1;
            bus.rd_en = 1'b1;
         end
         ST_LOAD:  bus.busy = 1'b1;
         ST_SHIFT: begin
            bus.busy = 1'b1;
            bus.SCLK = (phase >= PH_HI);
         end
         ST_LATCH: begin
            bus.busy = 1'b1;
            bus.LAT  = (lat_cnt >= LC_LAT);
         end
         ST_DONE:  bus.done = 1'b1;
         default:  ;
      endcase
   end

   assign bus.rd_addr = chan;

   // Counters advance only when the FSM actually stays/moves as planned, so abort freezes them
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         chan    <= '0;
         bit_sel <= '0;
         phase   <= '0;
         lat_cnt <= '0;
         r_data  <= '0;
      end else begin
         if (state == ST_IDLE && state_nx == ST_FETCH)
            chan <= CHAN_TOP;
         else if (state == ST_SHIFT && state_nx == ST_FETCH)
            chan <= chan - 1'b1;

         if (state == ST_LOAD) begin
            r_data  <= bus.rd_data;
            bit_sel <= BSEL_TOP;
         end else if (state == ST_SHIFT && state_nx == ST_SHIFT && ph_wrap) begin
            bit_sel <= bit_sel - 1'b1;
         end

         if (state == ST_SHIFT && state_nx == ST_SHIFT)
            phase <= ph_wrap ? '0 : phase + 1'b1;
         else
            phase <= '0;

         if (state == ST_LATCH && state_nx == ST_LATCH)
            lat_cnt <= lat_cnt + 1'b1;
         else
            lat_cnt <= '0;
      end
   end

   led_band_GS_controller #(
      .COLOR_DATA_WIDTH (COLOR_DATA_WIDTH),
      .NB_ADDED_LSB_BITS(NB_ADDED_LSB_BITS)
   ) u_gs_ctrl (
      .bit_sel(bit_sel),
      .r_data (r_data),
      .sout   (bus.SOUT)
   );

endmodule

// File: tb/tb_led_band_gs_sequencer.sv
// Scoreboard bench: three sequencer configurations, expected SOUT bits and read addresses queued by stimulus.
module tb_led_band_gs_sequencer;

   logic clk;
   logic nrst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a: defaults (2 channels); b: SCLK_DIV=1, LAT_WIDTH=1, no pad; c: 3 pad bits
   led_band_gs_sequencer_if #(.COLOR_DATA_WIDTH(8), .NB_CHANNELS(2)) bus_a ();
   led_band_gs_sequencer_if #(.COLOR_DATA_WIDTH(8), .NB_CHANNELS(2)) bus_b ();
   led_band_gs_sequencer_if #(.COLOR_DATA_WIDTH(8), .NB_CHANNELS(2)) bus_c ();

   led_band_gs_sequencer #(.COLOR_DATA_WIDTH(8), .NB_ADDED_LSB_BITS(1), .NB_CHANNELS(2),
      .SCLK_DIV(2), .LAT_WIDTH(2)) dut_a (.clk(clk), .nrst(nrst), .bus(bus_a));
   led_band_gs_sequencer #(.COLOR_DATA_WIDTH(8), .NB_ADDED_LSB_BITS(0), .NB_CHANNELS(2),
      .SCLK_DIV(1), .LAT_WIDTH(1)) dut_b (.clk(clk), .nrst(nrst), .bus(bus_b));
   led_band_gs_sequencer #(.COLOR_DATA_WIDTH(8), .NB_ADDED_LSB_BITS(3), .NB_CHANNELS(2),
      .SCLK_DIV(2), .LAT_WIDTH(2)) dut_c (.clk(clk), .nrst(nrst), .bus(bus_c));

   logic [2:0] start, abort, busy, done, rd_en, addr, sclk, sout, lat;
   logic [7:0] mem [3][2];
   logic [7:0] rdd [3];

   assign bus_a.start = start[0];  assign bus_b.start = start[1];  assign bus_c.start = start[2];
   assign bus_a.abort = abort[0];  assign bus_b.abort = abort[1];  assign bus_c.abort = abort[2];
   assign bus_a.rd_data = rdd[0];  assign bus_b.rd_data = rdd[1];  assign bus_c.rd_data = rdd[2];
   assign busy  = {bus_c.busy,    bus_b.busy,    bus_a.busy};
   assign done  = {bus_c.done,    bus_b.done,    bus_a.done};
   assign rd_en = {bus_c.rd_en,   bus_b.rd_en,   bus_a.rd_en};
   assign addr  = {bus_c.rd_addr, bus_b.rd_addr, bus_a.rd_addr};
   assign sclk  = {bus_c.SCLK,    bus_b.SCLK,    bus_a.SCLK};
   assign sout  = {bus_c.SOUT,    bus_b.SOUT,    bus_a.SOUT};
   assign lat   = {bus_c.LAT,     bus_b.LAT,     bus_a.LAT};

   // frame buffer: data valid one clock after the read strobe
   always @(posedge clk)
      for (int d = 0; d < 3; d++)
         if (rd_en[d]) rdd[d] <= mem[d][addr[d]];

   typedef struct { int d; logic [31:0] v; } exp_t;
   exp_t bit_q[$];
   exp_t addr_q[$];
   exp_t mon_e;

   int errors = 0;
   int checks = 0;
   logic chk_on = 1'b1;

   int n_rise [3] = '{0, 0, 0};
   int n_hi   [3] = '{0, 0, 0};
   int n_lat  [3] = '{0, 0, 0};
   int n_latp [3] = '{0, 0, 0};
   int n_done [3] = '{0, 0, 0};
   int n_cyc  [3] = '{0, 0, 0};
   int n_brise[3] = '{0, 0, 0};
   logic [2:0] sclk_q = '0, lat_q = '0, busy_q = '0;
   int b_rise, b_hi, b_lat, b_latp, b_done, b_cyc, b_brise;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // monitor: pops expectations whenever a DUT shifts a bit or issues a read
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (sclk[d]) n_hi[d]++;
         if (sclk[d] && !sclk_q[d]) begin
            n_rise[d]++;
            if (bit_q.size() != 0) begin
               mon_e = bit_q.pop_front();
               chk($sformatf("dut%0d tag on SCLK rise", d), d, mon_e.d);
               chk($sformatf("dut%0d SOUT at rise %0d", d, n_rise[d]), sout[d], mon_e.v);
            end else if (chk_on) begin
               chk($sformatf("dut%0d unexpected SCLK rise", d), 1, 0);
            end
         end
         if (rd_en[d]) begin
            if (addr_q.size() != 0) begin
               mon_e = addr_q.pop_front();
               chk($sformatf("dut%0d tag on read", d), d, mon_e.d);
               chk($sformatf("dut%0d rd_addr", d), addr[d], mon_e.v);
            end else if (chk_on) begin
               chk($sformatf("dut%0d unexpected read", d), 1, 0);
            end
         end
         if (lat[d]) n_lat[d]++;
         if (lat[d] && !lat_q[d]) n_latp[d]++;
         if (busy[d] && !busy_q[d]) n_brise[d]++;
         if (busy[d] || done[d]) n_cyc[d]++;
         if (done[d]) begin
            n_done[d]++;
            chk($sformatf("dut%0d busy low while done", d), busy[d], 0);
         end
      end
      sclk_q <= sclk;
      lat_q  <= lat;
      busy_q <= busy;
   end

   task automatic push_bits(input int d, input logic [15:0] pat, input int n);
      for (int i = n - 1; i >= 0; i--) bit_q.push_back('{d: d, v: 32'(pat[i])});
   endtask

   task automatic push_addr(input int d, input int a);
      addr_q.push_back('{d: d, v: a});
   endtask

   task automatic snap(input int d);
      b_rise = n_rise[d]; b_hi = n_hi[d]; b_lat = n_lat[d]; b_latp = n_latp[d];
      b_done = n_done[d]; b_cyc = n_cyc[d]; b_brise = n_brise[d];
   endtask

   task automatic wait_done(input int d, input int lim, input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end while (!done[d] && n < lim);
      chk({tag, " done seen"}, done[d], 1);
   endtask

   task automatic run_frame(input int d, input string tag);
      @(negedge clk); start[d] = 1'b1;
      @(negedge clk); start[d] = 1'b0;
      wait_done(d, 400, tag);
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_chk(input int d, input int rises, input int latw, input int cyc, input string tag);
      chk({tag, " SCLK rises"},       n_rise[d] - b_rise, rises);
      chk({tag, " SCLK high clks"},   n_hi[d] - b_hi, rises * (d == 1 ? 1 : 2));
      chk({tag, " LAT high clks"},    n_lat[d] - b_lat, latw);
      chk({tag, " LAT pulses"},       n_latp[d] - b_latp, 1);
      chk({tag, " done pulses"},      n_done[d] - b_done, 1);
      chk({tag, " frame cycles"},     n_cyc[d] - b_cyc, cyc);
      chk({tag, " busy rises"},       n_brise[d] - b_brise, 1);
      chk({tag, " bit queue empty"},  bit_q.size(), 0);
      chk({tag, " addr queue empty"}, addr_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic pre;
      int   n;
      int   r;
      logic p;
      nrst = 1'b0; start = '0; abort = '0;
      mem[0][1] = 8'hA5; mem[0][0] = 8'h3C;
      mem[1][1] = 8'hFF; mem[1][0] = 8'hFF;
      mem[2][1] = 8'hFF; mem[2][0] = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset busy", busy[0], 0);
      chk("reset done", done[0], 0);
      chk("reset rd_en", rd_en[0], 0);
      chk("reset rd_addr", addr[0], 0);
      chk("reset SCLK", sclk[0], 0);
      chk("reset LAT", lat[0], 0);
      chk("reset SOUT", sout[0], 0);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // basic frame: 0xA5 (chan 1) then 0x3C (chan 0), one zero LSB each
      push_addr(0, 1); push_addr(0, 0);
      push_bits(0, 16'h014A, 9); push_bits(0, 16'h0078, 9);
      snap(0);
      run_frame(0, "t1");
      frame_chk(0, 18, 2, 81, "t1");

      // start held through the whole frame and its done cycle
      push_addr(0, 1); push_addr(0, 0);
      push_bits(0, 16'h014A, 9); push_bits(0, 16'h0078, 9);
      snap(0);
      @(negedge clk); start[0] = 1'b1;
      wait_done(0, 400, "t2");
      @(negedge clk); start[0] = 1'b0;
      repeat (10) @(negedge clk);
      frame_chk(0, 18, 2, 81, "t2");

      // abort after the 5th rise of channel 1
      push_addr(0, 1);
      push_bits(0, 16'h0014, 5);
      snap(0);
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      r = 0; p = 1'b0; n = 0;
      while (r < 5 && n < 200) begin
         @(negedge clk); n++;
         if (sclk[0] && !p) r++;
         p = sclk[0];
      end
      chk("t3 reached 5th rise", r, 5);
      abort[0] = 1'b1;
      @(negedge clk); abort[0] = 1'b0;
      chk("t3 SCLK after abort", sclk[0], 0);
      chk("t3 busy after abort", busy[0], 0);
      chk("t3 rd_en after abort", rd_en[0], 0);
      chk("t3 LAT after abort", lat[0], 0);
      repeat (30) @(negedge clk);
      chk("t3 rises before abort", n_rise[0] - b_rise, 5);
      chk("t3 no LAT", n_lat[0] - b_lat, 0);
      chk("t3 no done", n_done[0] - b_done, 0);
      push_addr(0, 1); push_addr(0, 0);
      push_bits(0, 16'h014A, 9); push_bits(0, 16'h0078, 9);
      snap(0);
      run_frame(0, "t3b");
      frame_chk(0, 18, 2, 81, "t3b");

      // asynchronous reset while SCLK high, then while LAT high
      chk_on = 1'b0;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      n = 0;
      while (!sclk[0] && n < 200) begin @(negedge clk); n++; end
      pre = sclk[0];
      #1 nrst = 1'b0;
      #1;
      chk("t4 SCLK high before reset", pre, 1);
      chk("t4a SCLK", sclk[0], 0);
      chk("t4a LAT", lat[0], 0);
      chk("t4a busy", busy[0], 0);
      chk("t4a rd_en", rd_en[0], 0);
      @(negedge clk); nrst = 1'b1;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      n = 0;
      while (!lat[0] && n < 400) begin @(negedge clk); n++; end
      pre = lat[0];
      #1 nrst = 1'b0;
      #1;
      chk("t4 LAT high before reset", pre, 1);
      chk("t4b SCLK", sclk[0], 0);
      chk("t4b LAT", lat[0], 0);
      chk("t4b busy", busy[0], 0);
      chk("t4b rd_en", rd_en[0], 0);
      @(negedge clk); nrst = 1'b1;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;

      // fast clocking, no pad bits, all-ones data
      push_addr(1, 1); push_addr(1, 0);
      push_bits(1, 16'h00FF, 8); push_bits(1, 16'h00FF, 8);
      snap(1);
      run_frame(1, "t5");
      frame_chk(1, 16, 1, 39, "t5");

      // 3 pad bits: channel 0 carries 0x00, then 0xFF
      push_addr(2, 1); push_addr(2, 0);
      push_bits(2, 16'h07F8, 11); push_bits(2, 16'h0000, 11);
      snap(2);
      run_frame(2, "t6a");
      frame_chk(2, 22, 2, 97, "t6a");
      mem[2][1] = 8'h00; mem[2][0] = 8'hFF;
      push_addr(2, 1); push_addr(2, 0);
      push_bits(2, 16'h0000, 11); push_bits(2, 16'h07F8, 11);
      snap(2);
      run_frame(2, "t6b");
      frame_chk(2, 22, 2, 97, "t6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
